sd_fifo_sched: RTL and testbench

//   SD-clock-side access scheduler for the four-channel SD/Wishbone FIFO bank. Shares the

---
 rtl/sd_fifo_sched_if.sv | 27 ++
 rtl/sd_fifo_sched.sv | 97 +++++++++
 tb/tb_sd_fifo_sched.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_fifo_sched_if.sv
// Bus bundle between the SD-side access scheduler, its four requesters and the FIFO bank SD port.
interface sd_fifo_sched_if;
  logic [3:0] req;
  logic [7:0] cmd_wdat;
  logic [7:0] dat_wdat;
  logic [3:0] gnt;
  logic [3:0] rvalid;
  logic [7:0] rdata;
  logic       busy;
  logic [1:0] sd_adr_o;
  logic [7:0] sd_dat_o;
  logic       sd_we_o;
  logic       sd_re_o;
  logic [7:0] sd_dat_i;
  logic [3:0] fifo_full_i;
  logic [3:0] fifo_empty_i;

  modport master (
    input  req, cmd_wdat, dat_wdat, sd_dat_i, fifo_full_i, fifo_empty_i,
    output gnt, rvalid, rdata, busy, sd_adr_o, sd_dat_o, sd_we_o, sd_re_o
  );

  modport slave (
    output req, cmd_wdat, dat_wdat, sd_dat_i, fifo_full_i, fifo_empty_i,
    input  gnt, rvalid, rdata, busy, sd_adr_o, sd_dat_o, sd_we_o, sd_re_o
  );
endinterface

// File: rtl/sd_fifo_sched.sv
// Round-robin scheduler sharing the FIFO bank SD port among cmd/data TX pops and RX pushes,
// with bounded bursts and combinational full/empty gating.
module sd_fifo_sched #(
  parameter int BURST_MAX = 8,
  parameter int CNT_W     = 4
) (
  input logic             sd_clk,
  input logic             rst_n,
  sd_fifo_sched_if.master bus
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t           r_state;
  logic [1:0]       r_owner;
  logic [1:0]       r_last;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_rvalid;

  logic [3:0]       w_ok;
  logic [3:0]       w_elig;
  logic [3:0]       w_gnt;
  logic             w_ownOk;
  logic [1:0]       w_pick;
  logic             w_any;
  logic [CNT_W-1:0] w_cntNext;
  logic             w_burstEnd;
  logic             w_unused;

  // Pops (ch0, ch2) need data present; pushes (ch1, ch3) need room.
  assign w_ok      = {~bus.fifo_full_i[3], ~bus.fifo_empty_i[2],
                      ~bus.fifo_full_i[1], ~bus.fifo_empty_i[0]};
  assign w_elig    = bus.req & w_ok;
  assign w_ownOk   = bus.req[r_owner] & w_ok[r_owner];
  assign w_gnt     = (r_state == BURST && w_ownOk) ? (4'b0001 << r_owner) : 4'b0000;
  assign w_cntNext = r_cnt + 1'b1;
  assign w_burstEnd = (w_cntNext == CNT_W'(BURST_MAX));
  assign w_unused  = ^{bus.fifo_full_i[2], bus.fifo_full_i[0],
                       bus.fifo_empty_i[3], bus.fifo_empty_i[1]};

  // Descending scan so the nearest eligible requester after r_last wins.
  always_comb begin
    w_pick = r_last;
    w_any  = 1'b0;
    for (int k = 4; k >= 1; k--) begin
      if (w_elig[r_last + 2'(k)]) begin
        w_pick = r_last + 2'(k);
        w_any  = 1'b1;
      end
    end
  end

  always_ff @(posedge sd_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_owner  <= 2'd0;
      r_last   <= 2'd3;
      r_cnt    <= '0;
      r_rvalid <= 4'b0000;
    end else begin
      r_rvalid <= w_gnt & 4'b0101;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_owner <= w_pick;
            r_state <= BURST;
            r_cnt   <= '0;
          end
        end
        BURST: begin
          if (w_ownOk) begin
            r_cnt <= w_cntNext;
            if (w_burstEnd) begin
              r_state <= IDLE;
              r_last  <= r_owner;
            end
          end else begin
            r_state <= IDLE;
            r_last  <= r_owner;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Outside a burst the port idles on channel 0 with the cmd push data.
  assign bus.gnt      = w_gnt;
  assign bus.rvalid   = r_rvalid;
  assign bus.rdata    = bus.sd_dat_i;
  assign bus.busy     = (r_state == BURST);
  assign bus.sd_adr_o = (r_state == BURST) ? r_owner : 2'd0;
  assign bus.sd_dat_o = (r_state == BURST && r_owner != 2'd1) ? bus.dat_wdat : bus.cmd_wdat;
  assign bus.sd_re_o  = w_gnt[0] | w_gnt[2];
  assign bus.sd_we_o  = w_gnt[1] | w_gnt[3];

endmodule

// File: tb/tb_sd_fifo_sched.sv
// Bench for sd_fifo_sched: directed scenarios plus random traffic checked every cycle
// against an ownership-period model of the arbiter.
module tb_sd_fifo_sched;
  localparam int BURST_MAX = 8;

  logic sdClk = 1'b0;
  logic rstN  = 1'b0;
  int   checks = 0;
  int   errors = 0;

  sd_fifo_sched_if bus();

  sd_fifo_sched #(.BURST_MAX(BURST_MAX), .CNT_W(4)) dut (
    .sd_clk (sdClk),
    .rst_n  (rstN),
    .bus    (bus)
  );

  always #5 sdClk = ~sdClk;

  logic [3:0] dReq   = 4'b0000;
  logic [3:0] dFull  = 4'b0000;
  logic [3:0] dEmpty = 4'b0000;
  logic [7:0] dCmd   = 8'h00;
  logic [7:0] dDat   = 8'h00;

  // Model: who holds the port, how many accesses it has had, and who held it last.
  bit         mBusy   = 1'b0;
  int         mOwner  = 0;
  int         mLast   = 3;
  int         mCnt    = 0;
  logic [3:0] mRvalid = 4'b0000;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] okVec();
    return {~bus.fifo_full_i[3], ~bus.fifo_empty_i[2], ~bus.fifo_full_i[1], ~bus.fifo_empty_i[0]};
  endfunction

  function automatic logic [3:0] modelGnt();
    logic [3:0] ok;
    ok = okVec();
    if (mBusy && bus.req[mOwner] && ok[mOwner]) return 4'b0001 << mOwner;
    return 4'b0000;
  endfunction

  always @(negedge rstN) begin
    mBusy   = 1'b0;
    mOwner  = 0;
    mLast   = 3;
    mCnt    = 0;
    mRvalid = 4'b0000;
  end

  always @(posedge sdClk) begin : modelStep
    logic [3:0] g;
    logic [3:0] el;
    bit found;
    int c;
    if (rstN) begin
      g  = modelGnt();
      el = bus.req & okVec();
      mRvalid = g & 4'b0101;
      if (!mBusy) begin
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
          c = (mLast + k) % 4;
          if (!found && el[c]) begin
            found  = 1'b1;
            mOwner = c;
            mBusy  = 1'b1;
            mCnt   = 0;
          end
        end
      end else if (g != 4'b0000) begin
        mCnt++;
        if (mCnt == BURST_MAX) begin
          mBusy = 1'b0;
          mLast = mOwner;
        end
      end else begin
        mBusy = 1'b0;
        mLast = mOwner;
      end
    end
  end

  always @(negedge sdClk) begin : compareProc
    logic [3:0] g;
    g = modelGnt();
    checkOutput("gnt", 32'(bus.gnt), 32'(g));
    checkOutput("rvalid", 32'(bus.rvalid), 32'(mRvalid));
    checkOutput("busy", 32'(bus.busy), 32'(mBusy));
    checkOutput("sd_re_o", 32'(bus.sd_re_o), 32'(|(g & 4'b0101)));
    checkOutput("sd_we_o", 32'(bus.sd_we_o), 32'(|(g & 4'b1010)));
    checkOutput("sd_adr_o", 32'(bus.sd_adr_o), mBusy ? 32'(mOwner) : 32'd0);
    checkOutput("sd_dat_o", 32'(bus.sd_dat_o),
                (mBusy && mOwner != 1) ? 32'(bus.dat_wdat) : 32'(bus.cmd_wdat));
    checkOutput("rdata", 32'(bus.rdata), 32'(bus.sd_dat_i));
  end

  task automatic drive();
    bus.req          = dReq;
    bus.fifo_full_i  = dFull;
    bus.fifo_empty_i = dEmpty;
    bus.cmd_wdat     = dCmd;
    bus.dat_wdat     = dDat;
    bus.sd_dat_i     = 8'($urandom);
  endtask

  task automatic applyStimulus();
    @(posedge sdClk);
    #1;
    drive();
  endtask

  task automatic doReset();
    @(posedge sdClk);
    #1;
    rstN = 1'b0;
    repeat (2) @(posedge sdClk);
    #1;
    rstN = 1'b1;
    drive();
  endtask

  int gntCount[4];
  int weCount;
  int quietErr;

  initial begin
    drive();
    repeat (2) @(posedge sdClk);

    // Single pop requester: grants in cycles 1 and 2, data valid a cycle later.
    dReq = 4'b0001;
    doReset();
    #2 checkOutput("t1 reset gnt", 32'(bus.gnt), 32'd0);
    checkOutput("t1 reset sd_dat_o", 32'(bus.sd_dat_o), 32'(dCmd));
    applyStimulus();
    #2 checkOutput("t1 gnt c1", 32'(bus.gnt), 32'h1);
    checkOutput("t1 re c1", 32'(bus.sd_re_o), 32'h1);
    checkOutput("t1 adr c1", 32'(bus.sd_adr_o), 32'h0);
    applyStimulus();
    #2 checkOutput("t1 gnt c2", 32'(bus.gnt), 32'h1);
    checkOutput("t1 rvalid c2", 32'(bus.rvalid), 32'h1);
    dReq = 4'b0000;
    applyStimulus();
    #2 checkOutput("t1 rvalid c3", 32'(bus.rvalid), 32'h1);
    checkOutput("t1 gnt c3", 32'(bus.gnt), 32'h0);

    // All four requesting: 8 grants each, owners in order 0..3 with one bubble between.
    dReq = 4'b1111;
    doReset();
    for (int i = 0; i < 4; i++) gntCount[i] = 0;
    for (int s = 1; s <= 36; s++) begin
      applyStimulus();
      #2;
      for (int i = 0; i < 4; i++) if (bus.gnt[i]) gntCount[i]++;
      if (s == 10) checkOutput("t2 owner at c10", 32'(bus.gnt), 32'h2);
      if (s == 9)  checkOutput("t2 bubble at c9", 32'(bus.gnt), 32'h0);
    end
    for (int i = 0; i < 4; i++) checkOutput($sformatf("t2 gnt count r%0d", i), 32'(gntCount[i]), 32'd8);

    // Push stream stopped by a full flag after the third grant.
    dReq = 4'b0010;
    doReset();
    weCount = 0;
    for (int s = 1; s <= 10; s++) begin
      if (s == 4) dFull = 4'b0010;
      applyStimulus();
      #2 if (bus.sd_we_o) weCount++;
    end
    checkOutput("t3 we pulses", 32'(weCount), 32'd3);
    checkOutput("t3 busy after full", 32'(bus.busy), 32'd0);
    dFull = 4'b0000;

    // Pop on empty channel is held off until the flag clears.
    dReq = 4'b0100;
    dEmpty = 4'b0100;
    doReset();
    quietErr = 0;
    for (int s = 1; s <= 5; s++) begin
      applyStimulus();
      #2 if (bus.gnt != 4'b0000 || bus.sd_re_o) quietErr++;
    end
    checkOutput("t4 no access while empty", 32'(quietErr), 32'd0);
    dEmpty = 4'b0000;
    applyStimulus();
    #2 checkOutput("t4 gnt same cycle as clear", 32'(bus.gnt), 32'h0);
    applyStimulus();
    #2 checkOutput("t4 gnt next-but-one", 32'(bus.gnt), 32'h4);

    // Command push data routed to the bank.
    dReq = 4'b0010;
    dCmd = 8'hA5;
    dDat = 8'h3C;
    doReset();
    applyStimulus();
    #2 checkOutput("t5 sd_dat_o", 32'(bus.sd_dat_o), 32'hA5);
    checkOutput("t5 sd_adr_o", 32'(bus.sd_adr_o), 32'h1);
    checkOutput("t5 sd_we_o", 32'(bus.sd_we_o), 32'h1);

    // Asynchronous reset in the middle of a burst.
    dReq = 4'b0001;
    doReset();
    repeat (5) applyStimulus();
    #2 checkOutput("t6 rvalid before reset", 32'(bus.rvalid), 32'h1);
    rstN = 1'b0;
    #1 checkOutput("t6 gnt in reset", 32'(bus.gnt), 32'h0);
    checkOutput("t6 rvalid in reset", 32'(bus.rvalid), 32'h0);
    checkOutput("t6 busy in reset", 32'(bus.busy), 32'h0);
    dReq = 4'b1111;
    @(posedge sdClk);
    #1;
    rstN = 1'b1;
    drive();
    applyStimulus();
    #2 checkOutput("t6 first gnt after reset", 32'(bus.gnt), 32'h1);

    // Random traffic; requests tend to persist so full bursts occur.
    dCmd = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) dReq = 4'($urandom);
      dFull  = ($urandom_range(3) == 0) ? 4'($urandom) : 4'b0000;
      dEmpty = ($urandom_range(3) == 0) ? 4'($urandom) : 4'b0000;
      dCmd   = 8'($urandom);
      dDat   = 8'($urandom);
      applyStimulus();
    end

    @(posedge sdClk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
